// File: rtl/vlsu_data_mem_resp.sv
// OBI-style data-memory responder: word-addressed RAM with fixed response
// latency, bounded outstanding transactions and an external grant stall.
//
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   data_req_i         request valid from initiator
//   data_gnt_o         request accepted this cycle (combinational)
//   data_we_i          1 = write, 0 = read
//   data_be_i          byte enables, bit n qualifies lane n
//   data_addr_i        byte address, bits [1:0] ignored
//   data_wdata_i       write data
//   data_rvalid_o      one response per granted transaction
//   data_rdata_o       read data, 0 for writes and when idle
//   data_err_o         granted address was out of range
//   gnt_stall_i        forces data_gnt_o low
module vlsu_data_mem_resp #(
    parameter int          DEPTH_WORDS     = 1024,
    parameter int          RD_LATENCY      = 1,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_req_i,
    output logic        data_gnt_o,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,
    input  logic        gnt_stall_i
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [32:0]   SPAN    = 33'(DEPTH_WORDS) * 33'd4;
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

    logic [31:0] mem [DEPTH_WORDS];

    logic [31:0]           offset;
    logic                  in_range;
    logic [AW-1:0]         word_idx;
    logic                  accept;
    logic [CW-1:0]         outstanding;
    logic [CW-1:0]         busy;
    logic [31:0]           rd_word;

    logic [RD_LATENCY-1:0] pipe_v;
    logic [RD_LATENCY-1:0] pipe_e;
    logic [31:0]           pipe_d [RD_LATENCY];

    // Offset relative to the window base; the unsigned compare also
    // rejects addresses below the base since they wrap to large values.
    assign offset   = data_addr_i - BASE_ADDR;
    assign in_range = {1'b0, offset} < SPAN;
    assign word_idx = offset[AW+1:2];
    assign rd_word  = mem[word_idx];

    // A response leaving this cycle frees its slot for a new grant.
    assign busy       = outstanding - CW'(data_rvalid_o);
    assign data_gnt_o = data_req_i & ~gnt_stall_i & ~reset
                      & (busy < MAX_CNT);
    assign accept     = data_req_i & data_gnt_o;

    always_ff @(posedge clk) begin
        if (accept && data_we_i && in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (data_be_i[b]) begin
                    mem[word_idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
                end
            end
        end
    end

    // Stage 0 captures the response at the accept edge, so a read sees
    // the RAM before any later write lands.
    always_ff @(posedge clk) begin
        if (reset) begin
            pipe_v <= '0;
            pipe_e <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                pipe_d[i] <= '0;
            end
        end else begin
            pipe_v[0] <= accept;
            pipe_e[0] <= accept & ~in_range;
            pipe_d[0] <= (accept && !data_we_i && in_range) ? rd_word : '0;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_e[i] <= pipe_e[i-1];
                pipe_d[i] <= pipe_d[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            outstanding <= '0;
        end else if (accept && !data_rvalid_o) begin
            outstanding <= outstanding + CW'(1);
        end else if (!accept && data_rvalid_o) begin
            outstanding <= outstanding - CW'(1);
        end
    end

    assign data_rvalid_o = pipe_v[RD_LATENCY-1] & ~reset;
    assign data_err_o    = data_rvalid_o & pipe_e[RD_LATENCY-1];
    assign data_rdata_o  = data_rvalid_o ? pipe_d[RD_LATENCY-1] : '0;

endmodule
